// File: rtl/spi_slave_sync_if.sv
// SPI pin and register-file handshake bundle for spi_slave_sync.
// The slave modport is the DUT side; the master modport is the SPI master plus register file.
interface spi_slave_sync_if #(
  parameter int WORD_W = 16
);
  logic              sck;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [WORD_W-1:0] tx_data;
  logic              tx_ack;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_abort;
  logic              busy;

  modport slave (
    input  sck, cs, mosi, tx_data,
    output miso, miso_oe, tx_ack, rx_data, rx_valid, frame_abort, busy
  );

  modport master (
    output sck, cs, mosi, tx_data,
    input  miso, miso_oe, tx_ack, rx_data, rx_valid, frame_abort, busy
  );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI mode-3 slave. All SPI pins are oversampled into clk and edge-detected;
// nothing in this module is clocked by sck.
//
// state | meaning
// IDLE  | cs high, outputs parked
// SHIFT | data bits of a word: falls drive miso, rises sample mosi
// DUMMY | trailing sck cycles after a word, rises only counted
module spi_slave_sync #(
  parameter int WORD_W       = 16,
  parameter int DUMMY_CYCLES = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_sync_if.slave bus
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int DW = (DUMMY_CYCLES < 1) ? 1 : $clog2(DUMMY_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DUMMY} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_prev;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall;

  state_t            state_q, state_nxt;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_nxt;
  logic [DW-1:0]     dummy_q, dummy_nxt;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_nxt;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_nxt;
  logic [WORD_W-1:0] rx_data_q, rx_data_nxt;
  logic              miso_q, miso_nxt;
  logic              miso_oe_q;
  logic              rx_valid_q, rx_valid_nxt;
  logic              abort_q, abort_nxt;
  logic              tx_ack_c;

  // Synchronizers park at the bus idle levels so reset release creates no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_prev  <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      dummy_q    <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      dummy_q    <= dummy_nxt;
      tx_shift_q <= tx_shift_nxt;
      rx_shift_q <= rx_shift_nxt;
      rx_data_q  <= rx_data_nxt;
      miso_q     <= miso_nxt;
      miso_oe_q  <= ~cs_s;
      rx_valid_q <= rx_valid_nxt;
      abort_q    <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    bit_cnt_nxt  = bit_cnt_q;
    dummy_nxt    = dummy_q;
    tx_shift_nxt = tx_shift_q;
    rx_shift_nxt = rx_shift_q;
    rx_data_nxt  = rx_data_q;
    miso_nxt     = miso_q;
    rx_valid_nxt = 1'b0;
    abort_nxt    = 1'b0;
    tx_ack_c     = 1'b0;

    if (cs_s) begin
      // cs deassertion beats any sck edge seen in the same cycle
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      dummy_nxt   = '0;
      miso_nxt    = 1'b0;
      abort_nxt   = (state_q == SHIFT) && (bit_cnt_q != '0);
    end else begin
      case (state_q)
        IDLE, SHIFT: begin
          state_nxt = SHIFT;
          if (sck_fall) begin
            if (bit_cnt_q == '0) begin
              tx_shift_nxt = bus.tx_data;
              miso_nxt     = bus.tx_data[WORD_W-1];
              tx_ack_c     = 1'b1;
            end else begin
              tx_shift_nxt = tx_shift_q << 1;
              miso_nxt     = tx_shift_q[WORD_W-2];
            end
          end else if (sck_rise) begin
            rx_shift_nxt = (rx_shift_q << 1) | WORD_W'(mosi_s);
            if (bit_cnt_q == BW'(WORD_W - 1)) begin
              rx_data_nxt  = rx_shift_nxt;
              rx_valid_nxt = 1'b1;
              bit_cnt_nxt  = '0;
              state_nxt    = (DUMMY_CYCLES == 0) ? SHIFT : DUMMY;
            end else begin
              bit_cnt_nxt = bit_cnt_q + 1'b1;
            end
          end
        end
        DUMMY: begin
          if (sck_rise) begin
            if (int'(dummy_q) + 1 >= DUMMY_CYCLES) begin
              dummy_nxt = '0;
              state_nxt = SHIFT;
            end else begin
              dummy_nxt = dummy_q + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.tx_ack      = tx_ack_c;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.frame_abort = abort_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a mode-3 master model drives one DUT built with one dummy
// cycle and one built back-to-back; a scoreboard checks received and returned words.
module tb_spi_slave_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b1;
  logic        mosi = 1'b0;
  logic        cs_a = 1'b1;
  logic        cs_b = 1'b1;
  logic [15:0] txd_a = '0;
  logic [15:0] txd_b = '0;

  spi_slave_sync_if #(.WORD_W(16)) ifa ();
  spi_slave_sync_if #(.WORD_W(16)) ifb ();

  assign ifa.sck = sck;
  assign ifa.cs = cs_a;
  assign ifa.mosi = mosi;
  assign ifa.tx_data = txd_a;
  assign ifb.sck = sck;
  assign ifb.cs = cs_b;
  assign ifb.mosi = mosi;
  assign ifb.tx_data = txd_b;

  spi_slave_sync #(.WORD_W(16), .DUMMY_CYCLES(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  spi_slave_sync #(.WORD_W(16), .DUMMY_CYCLES(0), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int txc[2] = '{0, 0};
  int rxc[2] = '{0, 0};
  int abc[2] = '{0, 0};

  logic [15:0] exp_rx_a[$];
  logic [15:0] exp_rx_b[$];
  logic [15:0] exp_miso[$];
  logic [15:0] tx_q_a[$];
  logic [15:0] tx_q_b[$];
  logic [15:0] frame_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pop_word(inout logic [15:0] q[$]);
    if (q.size() == 0) return 16'hxxxx;
    return q.pop_front();
  endfunction

  // Register-file model: on each tx_ack the next queued word is presented after the capture edge.
  always @(negedge clk) begin
    if (ifa.tx_ack) begin
      txc[0]++;
      @(posedge clk);
      #1;
      if (tx_q_a.size() > 0) void'(tx_q_a.pop_front());
      if (tx_q_a.size() > 0) txd_a = tx_q_a[0];
    end
  end

  always @(negedge clk) begin
    if (ifb.tx_ack) begin
      txc[1]++;
      @(posedge clk);
      #1;
      if (tx_q_b.size() > 0) void'(tx_q_b.pop_front());
      if (tx_q_b.size() > 0) txd_b = tx_q_b[0];
    end
  end

  always @(negedge clk) begin
    if (ifa.rx_valid) begin
      rxc[0]++;
      chk("rx_data_a", 32'(ifa.rx_data), 32'(pop_word(exp_rx_a)));
    end
    if (ifb.rx_valid) begin
      rxc[1]++;
      chk("rx_data_b", 32'(ifb.rx_data), 32'(pop_word(exp_rx_b)));
    end
    if (ifa.frame_abort) abc[0]++;
    if (ifb.frame_abort) abc[1]++;
  end

  function automatic logic [21:0] outs_a();
    return {ifa.miso, ifa.miso_oe, ifa.tx_ack, ifa.rx_valid, ifa.frame_abort, ifa.busy, ifa.rx_data};
  endfunction

  function automatic logic [21:0] outs_b();
    return {ifb.miso, ifb.miso_oe, ifb.tx_ack, ifb.rx_valid, ifb.frame_abort, ifb.busy, ifb.rx_data};
  endfunction

  task automatic cs_low(input bit sel);
    @(posedge clk);
    #2;
    if (sel) cs_b = 1'b0;
    else cs_a = 1'b0;
    #29;
    chk("oe_on", 32'(sel ? ifb.miso_oe : ifa.miso_oe), 32'd1);
    chk("busy_on", 32'(sel ? ifb.busy : ifa.busy), 32'd1);
    #71;
  endtask

  task automatic cs_high(input bit sel);
    #50;
    if (sel) cs_b = 1'b1;
    else cs_a = 1'b1;
    #29;
    chk("oe_off", 32'(sel ? ifb.miso_oe : ifa.miso_oe), 32'd0);
    chk("busy_off", 32'(sel ? ifb.busy : ifa.busy), 32'd0);
    #71;
  endtask

  // Mode 3: drive mosi on the fall, sample miso 25 ns after the rise.
  task automatic word_xfer(input bit sel, input logic [15:0] w, input int nbits,
                           output logic [15:0] r);
    r = '0;
    for (int i = 15; i > 15 - nbits; i--) begin
      sck = 1'b0;
      mosi = w[i];
      #50;
      sck = 1'b1;
      #25;
      r[i] = sel ? ifb.miso : ifa.miso;
      #25;
    end
  endtask

  task automatic send_frame(input bit sel, input int dummy);
    logic [15:0] r;
    cs_low(sel);
    for (int k = 0; k < frame_q.size(); k++) begin
      if (sel) exp_rx_b.push_back(frame_q[k]);
      else exp_rx_a.push_back(frame_q[k]);
      word_xfer(sel, frame_q[k], 16, r);
      chk("miso_word", 32'(r), 32'(pop_word(exp_miso)));
      for (int d = 0; d < dummy; d++) begin
        sck = 1'b0;
        mosi = 1'b0;
        #50;
        sck = 1'b1;
        #50;
      end
    end
    cs_high(sel);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int s_tx, s_rx, s_ab;
    logic [15:0] r;

    #23;
    chk("reset_a", 32'(outs_a()), 32'd0);
    chk("reset_b", 32'(outs_b()), 32'd0);
    #20;
    rst_n = 1'b1;
    #50;

    // single word
    s_tx = txc[0]; s_rx = rxc[0]; s_ab = abc[0];
    tx_q_a = '{16'hA5C3};
    txd_a = 16'hA5C3;
    exp_miso.push_back(16'hA5C3);
    frame_q = '{16'h1234};
    send_frame(0, 1);
    chk("t1_rx_cnt", 32'(rxc[0] - s_rx), 32'd1);
    chk("t1_tx_cnt", 32'(txc[0] - s_tx), 32'd1);
    chk("t1_rx_hold", 32'(ifa.rx_data), 32'h1234);

    // three words under one cs, tx_data refreshed on each ack
    s_tx = txc[0]; s_rx = rxc[0];
    tx_q_a = '{16'h1111, 16'h2222, 16'h3333};
    txd_a = 16'h1111;
    exp_miso.push_back(16'h1111);
    exp_miso.push_back(16'h2222);
    exp_miso.push_back(16'h3333);
    frame_q = '{16'h0001, 16'h8000, 16'hFFFF};
    send_frame(0, 1);
    chk("t2_rx_cnt", 32'(rxc[0] - s_rx), 32'd3);
    chk("t2_tx_cnt", 32'(txc[0] - s_tx), 32'd3);
    chk("t2_abort", 32'(abc[0] - s_ab), 32'd0);

    // abort after 7 rises, then a clean word
    s_rx = rxc[0]; s_ab = abc[0];
    tx_q_a = '{16'h0F0F, 16'hC0DE};
    txd_a = 16'h0F0F;
    cs_low(0);
    word_xfer(0, 16'h1357, 7, r);
    cs_high(0);
    chk("t3_abort", 32'(abc[0] - s_ab), 32'd1);
    chk("t3_no_rx", 32'(rxc[0] - s_rx), 32'd0);
    chk("t3_rx_keep", 32'(ifa.rx_data), 32'hFFFF);
    exp_miso.push_back(16'hC0DE);
    frame_q = '{16'hBEEF};
    send_frame(0, 1);
    chk("t3_rx_cnt", 32'(rxc[0] - s_rx), 32'd1);
    chk("t3_abort_once", 32'(abc[0] - s_ab), 32'd1);

    // back-to-back words on the zero-dummy build
    s_tx = txc[1]; s_rx = rxc[1]; s_ab = abc[1];
    tx_q_b = '{16'hAAAA, 16'h5555};
    txd_b = 16'hAAAA;
    exp_miso.push_back(16'hAAAA);
    exp_miso.push_back(16'h5555);
    frame_q = '{16'hDEAD, 16'hBEEF};
    send_frame(1, 0);
    chk("t4_rx_cnt", 32'(rxc[1] - s_rx), 32'd2);
    chk("t4_tx_cnt", 32'(txc[1] - s_tx), 32'd2);
    chk("t4_abort", 32'(abc[1] - s_ab), 32'd0);

    // reset mid-word
    s_ab = abc[0];
    tx_q_a = '{16'h7777};
    txd_a = 16'h7777;
    cs_low(0);
    word_xfer(0, 16'hFFFF, 9, r);
    #10;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_async", 32'(outs_a()), 32'd0);
    cs_a = 1'b1;
    #40;
    chk("t5_rst_hold", 32'(outs_a()), 32'd0);
    rst_n = 1'b1;
    #100;
    s_tx = txc[0]; s_rx = rxc[0];
    tx_q_a = '{16'h3C3C};
    txd_a = 16'h3C3C;
    exp_miso.push_back(16'h3C3C);
    frame_q = '{16'h5A5A};
    send_frame(0, 1);
    chk("t5_rx_cnt", 32'(rxc[0] - s_rx), 32'd1);
    chk("t5_tx_cnt", 32'(txc[0] - s_tx), 32'd1);
    chk("t5_abort", 32'(abc[0] - s_ab), 32'd0);
    chk("t5_rx_data", 32'(ifa.rx_data), 32'h5A5A);

    chk("left_rx_a", 32'(exp_rx_a.size()), 32'd0);
    chk("left_rx_b", 32'(exp_rx_b.size()), 32'd0);
    chk("left_miso", 32'(exp_miso.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
